exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_if.sv | 38 +++
 rtl/exc_ctrl.sv | 114 +++++++++++
 tb/tb_exc_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// Bundles the write-back request inputs, the CSR commit outputs and the
// IF-stage redirect handshake of the exception controller.
interface exc_ctrl_if;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [4:0]  ws_exc;
  logic        ws_ertn;
  logic        int_pending;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        redirect_ready;

  logic        csr_wb_ex;
  logic [5:0]  csr_ecode;
  logic [31:0] csr_wb_pc;
  logic        csr_ertn;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] exc_count;

  // Pipeline / CSR side: drives the requests, consumes the commit and redirect.
  modport master (
    output ws_valid, ws_pc, ws_exc, ws_ertn, int_pending,
           csr_eentry, csr_era, redirect_ready,
    input  csr_wb_ex, csr_ecode, csr_wb_pc, csr_ertn, flush,
           redirect_valid, redirect_pc, busy, exc_count
  );

  // Controller side.
  modport slave (
    input  ws_valid, ws_pc, ws_exc, ws_ertn, int_pending,
           csr_eentry, csr_era, redirect_ready,
    output csr_wb_ex, csr_ecode, csr_wb_pc, csr_ertn, flush,
           redirect_valid, redirect_pc, busy, exc_count
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception / ERTN commit controller. Takes one WB-stage event at a time,
// strobes it into the CSR file, then redirects fetch and waits for IF to
// accept the new PC. Everything arriving while a sequence runs is dropped.
module exc_ctrl (
  input logic     clk,
  input logic     resetn,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_ERTN = 1'b1
  } kind_t;

  state_t      state_q,    state_d;
  kind_t       kind_q,     kind_d;
  logic [31:0] faultPc_q,  faultPc_d;
  logic [5:0]  ecode_q,    ecode_d;
  logic [31:0] targetPc_q, targetPc_d;
  logic [15:0] excCount_q, excCount_d;

  logic [5:0]  selEcode;
  logic        excReq;
  logic        ertnReq;

  // Pick the highest-priority cause; an interrupt beats every synchronous flag.
  always_comb begin
    selEcode = 6'h00;
    if (bus.int_pending)    selEcode = 6'h00;
    else if (bus.ws_exc[0]) selEcode = 6'h08;
    else if (bus.ws_exc[1]) selEcode = 6'h0D;
    else if (bus.ws_exc[2]) selEcode = 6'h0B;
    else if (bus.ws_exc[3]) selEcode = 6'h0C;
    else if (bus.ws_exc[4]) selEcode = 6'h09;
  end

  // An exception swallows a simultaneous ERTN; nothing counts without ws_valid.
  assign excReq  = bus.ws_valid & (bus.int_pending | (|bus.ws_exc));
  assign ertnReq = bus.ws_valid & bus.ws_ertn & ~excReq;

  // Next-state logic: accept only in IDLE, capture target during COMMIT.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    faultPc_d  = faultPc_q;
    ecode_d    = ecode_q;
    targetPc_d = targetPc_q;
    excCount_d = excCount_q;
    case (state_q)
      IDLE: begin
        if (excReq) begin
          faultPc_d = bus.ws_pc;
          ecode_d   = selEcode;
          kind_d    = KIND_EXC;
          state_d   = COMMIT;
        end else if (ertnReq) begin
          faultPc_d = 32'h0;
          ecode_d   = 6'h00;
          kind_d    = KIND_ERTN;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        targetPc_d = (kind_q == KIND_EXC) ? bus.csr_eentry : bus.csr_era;
        if ((kind_q == KIND_EXC) && (excCount_q != 16'hFFFF)) begin
          excCount_d = excCount_q + 16'd1;
        end
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      kind_q     <= KIND_EXC;
      faultPc_q  <= 32'h0;
      ecode_q    <= 6'h00;
      targetPc_q <= 32'h0;
      excCount_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      faultPc_q  <= faultPc_d;
      ecode_q    <= ecode_d;
      targetPc_q <= targetPc_d;
      excCount_q <= excCount_d;
    end
  end

  assign bus.csr_wb_ex      = (state_q == COMMIT) && (kind_q == KIND_EXC);
  assign bus.csr_ertn       = (state_q == COMMIT) && (kind_q == KIND_ERTN);
  assign bus.csr_ecode      = bus.csr_wb_ex ? ecode_q : 6'h00;
  assign bus.csr_wb_pc      = bus.csr_wb_ex ? faultPc_q : 32'h0;
  assign bus.flush          = (state_q != IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = bus.redirect_valid ? targetPc_q : 32'h0;
  assign bus.exc_count      = excCount_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: the driver predicts each commit and redirect
// from the architectural rules, and an independent monitor checks them.
module tb_exc_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    bit          isExc;
    logic [5:0]  ecode;
    logic [31:0] pc;
    int          cycle;
  } commit_t;

  typedef struct {
    logic [31:0] target;
    logic [15:0] count;
  } redir_t;

  commit_t commitQ[$];
  redir_t  redirQ[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int modelCount = 0;

  // Free-running cycle index used for latency bookkeeping.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Architectural cause priority: interrupt first, then flag bits in order
  // ADEF, INE, SYS, BRK, ALE.
  function automatic logic [5:0] refEcode(input bit intp, input logic [4:0] exc);
    logic [5:0] codes [5];
    codes = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
    if (intp) return 6'h00;
    for (int i = 0; i < 5; i++) begin
      if (exc[i]) return codes[i];
    end
    return 6'h00;
  endfunction

  task automatic driveNoise();
    bus.ws_valid    = 1'($urandom);
    bus.ws_exc      = 5'($urandom);
    bus.ws_ertn     = 1'($urandom);
    bus.int_pending = 1'($urandom);
    bus.ws_pc       = $urandom;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctl"}, 64'({bus.csr_wb_ex, bus.csr_ertn, bus.flush,
                bus.redirect_valid, bus.busy, bus.csr_ecode, bus.exc_count}), 64'h0);
    checkOutput({name, "_pc"}, {bus.csr_wb_pc, bus.redirect_pc}, 64'h0);
  endtask

  // Issue one WB-stage event from an idle DUT and run it to completion.
  // abortInRedirect replaces the handshake with a reset pulse.
  task automatic applyStimulus(input bit valid, input logic [4:0] exc, input bit ertn,
                               input bit intp, input logic [31:0] pc,
                               input logic [31:0] eentry, input logic [31:0] era,
                               input int holdCycles, input bit abortInRedirect);
    bit isExc;
    bit isErtn;
    isExc  = valid && (intp || (exc != 5'd0));
    isErtn = valid && ertn && !isExc;
    bus.ws_valid       = valid;
    bus.ws_exc         = exc;
    bus.ws_ertn        = ertn;
    bus.int_pending    = intp;
    bus.ws_pc          = pc;
    bus.csr_eentry     = eentry;
    bus.csr_era        = era;
    bus.redirect_ready = 1'b0;
    if (isExc || isErtn) begin
      if (isExc && modelCount < 65535) modelCount++;
      commitQ.push_back('{isExc, isExc ? refEcode(intp, exc) : 6'h00,
                          isExc ? pc : 32'h0, cycle + 1});
      redirQ.push_back('{isExc ? eentry : era, 16'(modelCount)});
    end
    @(posedge clk); #1;
    driveNoise();
    if (!(isExc || isErtn)) begin
      checkOutput("no_request_busy", 64'(bus.busy), 64'h0);
      bus.ws_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 4 && !bus.redirect_valid; i++) begin
      @(posedge clk); #1;
      driveNoise();
    end
    checkOutput("redirect_reached", 64'(bus.redirect_valid), 64'h1);
    if (abortInRedirect) begin
      resetn = 1'b0;
      commitQ.delete();
      redirQ.delete();
      modelCount = 0;
      @(posedge clk); #1;
      resetn = 1'b1;
      bus.ws_valid = 1'b0;
      checkAllZero("reset_abort");
      @(posedge clk); #1;
      checkAllZero("reset_abort_next");
      return;
    end
    repeat (holdCycles) begin
      @(posedge clk); #1;
      driveNoise();
    end
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.ws_valid       = 1'b0;
    bus.redirect_ready = 1'($urandom);
    checkOutput("idle_after_handshake", 64'({bus.busy, bus.flush, bus.redirect_valid}), 64'h0);
  endtask

  // Monitor: pops expected commits/redirects whenever the DUT presents them.
  bit          prevValid = 1'b0;
  logic [31:0] prevPc = 32'h0;
  int          redirExpCycle = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      prevValid = 1'b0;
    end else begin
      if (bus.csr_wb_ex || bus.csr_ertn) begin
        if (commitQ.size() == 0) begin
          checkOutput("unexpected_strobe", 64'({bus.csr_wb_ex, bus.csr_ertn}), 64'h0);
        end else begin
          commit_t e;
          e = commitQ.pop_front();
          checkOutput("commit_kind", 64'({bus.csr_wb_ex, bus.csr_ertn}), e.isExc ? 64'h2 : 64'h1);
          checkOutput("csr_ecode", 64'(bus.csr_ecode), 64'(e.ecode));
          checkOutput("csr_wb_pc", 64'(bus.csr_wb_pc), 64'(e.pc));
          checkOutput("commit_latency", 64'(cycle), 64'(e.cycle));
          checkOutput("flush_commit", 64'(bus.flush), 64'h1);
        end
        redirExpCycle = cycle + 1;
      end
      if (!bus.csr_wb_ex) begin
        checkOutput("ecode_pc_idle_zero", 64'({bus.csr_ecode, bus.csr_wb_pc}), 64'h0);
      end
      if (bus.redirect_valid) begin
        if (!prevValid) checkOutput("redirect_latency", 64'(cycle), 64'(redirExpCycle));
        else            checkOutput("redirect_pc_stable", 64'(bus.redirect_pc), 64'(prevPc));
        checkOutput("flush_busy_redirect", 64'({bus.flush, bus.busy}), 64'h3);
        if (bus.redirect_ready) begin
          if (redirQ.size() == 0) begin
            checkOutput("unexpected_handshake", 64'(bus.redirect_valid), 64'h0);
          end else begin
            redir_t r;
            r = redirQ.pop_front();
            checkOutput("redirect_pc", 64'(bus.redirect_pc), 64'(r.target));
            checkOutput("exc_count", 64'(bus.exc_count), 64'(r.count));
          end
        end
        prevValid = !bus.redirect_ready;
        prevPc    = bus.redirect_pc;
      end else begin
        checkOutput("redirect_pc_zero", 64'(bus.redirect_pc), 64'h0);
        prevValid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.ws_valid       = 1'b0;
    bus.ws_pc          = 32'h0;
    bus.ws_exc         = 5'h0;
    bus.ws_ertn        = 1'b0;
    bus.int_pending    = 1'b0;
    bus.csr_eentry     = 32'h0;
    bus.csr_era        = 32'h0;
    bus.redirect_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    checkAllZero("reset_state");

    $display("[TB] directed: SYS, priority, ERTN, exc+ERTN, invalid");
    applyStimulus(1, 5'b00100, 0, 0, 32'h1C000100, 32'h1C008000, 32'h0, 0, 0);
    checkOutput("count_after_sys", 64'(bus.exc_count), 64'h1);
    applyStimulus(1, 5'b10110, 0, 1, 32'h1C000200, 32'h1C008000, 32'h0, 1, 0);
    applyStimulus(1, 5'b10110, 0, 0, 32'h1C000204, 32'h1C008000, 32'h0, 0, 0);
    applyStimulus(1, 5'b00000, 1, 0, 32'h1C000300, 32'h1C008000, 32'h1C000104, 0, 0);
    checkOutput("count_after_ertn", 64'(bus.exc_count), 64'h3);
    applyStimulus(1, 5'b00001, 1, 0, 32'h1C000400, 32'h1C009000, 32'h1C000104, 0, 0);
    applyStimulus(0, 5'b11111, 1, 1, 32'h1C000500, 32'h1C009000, 32'h1C000104, 0, 0);
    applyStimulus(1, 5'b00000, 0, 0, 32'h1C000504, 32'h1C009000, 32'h1C000104, 0, 0);

    $display("[TB] directed: backpressure and single flags");
    applyStimulus(1, 5'b01000, 0, 0, 32'h1C000600, 32'h1C00A000, 32'h0, 5, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'(1 << i), 0, 0, 32'h1C001000 + 32'(i * 4), 32'h1C00B000, 32'h0, i, 0);
    end

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      logic [4:0] exc;
      exc = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
      applyStimulus($urandom_range(0, 4) != 0, exc, 1'($urandom), $urandom_range(0, 5) == 0,
                    $urandom, $urandom, $urandom, $urandom_range(0, 3), 0);
    end

    $display("[TB] reset during REDIRECT");
    applyStimulus(1, 5'b00100, 0, 0, 32'h1C000700, 32'h1C008000, 32'h0, 0, 1);
    applyStimulus(1, 5'b00010, 0, 0, 32'h1C000704, 32'h1C008000, 32'h0, 0, 0);
    checkOutput("count_after_reset", 64'(bus.exc_count), 64'h1);

    $display("[TB] saturation from preloaded 0xFFFF");
    force dut.excCount_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.excCount_q;
    modelCount = 65535;
    checkOutput("count_preload", 64'(bus.exc_count), 64'hFFFF);
    applyStimulus(1, 5'b10000, 0, 0, 32'h1C000800, 32'h1C008000, 32'h0, 0, 0);
    @(posedge clk); #1;
    checkOutput("count_saturated", 64'(bus.exc_count), 64'hFFFF);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(commitQ.size() + redirQ.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
